irrigation_zone_scheduler: RTL and testbench

IRRIGATION_ZONE_SCHEDULER -- requirements
Module: irrigation_zone_scheduler

---
 rtl/irrigation_zone_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_scheduler.sv
// Tank-fed irrigation scheduler: fills the tank, then waters eligible zones round-robin,
// optionally dosing fertiliser on spray turns followed by a line-cleaning phase.
module irrigation_zone_scheduler #(
    parameter int ZONES       = 4,
    parameter int LEVEL_BITS  = 3,
    parameter int DRIP_TICKS  = 4,
    parameter int SPRAY_TICKS = 2,
    parameter int QUANTUM     = 2,
    parameter int CLEAN_TICKS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic [2*ZONES-1:0]    zone_mode_i,
    input  logic                  fertilise_req_i,
    output logic [LEVEL_BITS-1:0] water_level_o,
    output logic                  filling_o,
    output logic                  watering_o,
    output logic [ZONES-1:0]      active_zone_o,
    output logic                  fertilising_o,
    output logic                  cleaning_o,
    output logic                  alarm_o,
    output logic [ZONES-1:0]      zone_error_o
);
    localparam int PW   = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int TMX  = (DRIP_TICKS > SPRAY_TICKS) ? DRIP_TICKS : SPRAY_TICKS;
    localparam int TMAX = (TMX > CLEAN_TICKS) ? TMX : CLEAN_TICKS;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {FILL, SELECT, WATER, CLEAN} state_e;

    state_e                state_q, state_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic [PW-1:0]         rr_q, rr_d, idx_q, idx_d, sel_idx;
    logic [1:0]            mode_q, mode_d, sel_mode, live_mode;
    logic [CW-1:0]         tcnt_q, tcnt_d, lim_m1;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  pend_q, pend_d, fert_q, fert_d, pend_clr, found;
    logic [1:0]            scan_m;
    int                    scan_j;

    logic                  filling_q, watering_q, cleaning_q, alarm_q;
    logic [ZONES-1:0]      active_q;

    always_comb begin
        for (int i = 0; i < ZONES; i++)
            zone_error_o[i] = (zone_mode_i[2*i +: 2] == 2'b11);
    end

    // First eligible zone after the round-robin pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_mode = 2'b00;
        scan_j   = 0;
        scan_m   = 2'b00;
        for (int k = 1; k <= ZONES; k++) begin
            scan_j = (int'(rr_q) + k) % ZONES;
            scan_m = zone_mode_i[2*scan_j +: 2];
            if (!found && (scan_m == 2'b01 || scan_m == 2'b10)) begin
                found    = 1'b1;
                sel_idx  = PW'(scan_j);
                sel_mode = scan_m;
            end
        end
    end

    assign live_mode = zone_mode_i[2*int'(idx_q) +: 2];
    assign lim_m1    = (mode_q == 2'b10) ? CW'(SPRAY_TICKS - 1) : CW'(DRIP_TICKS - 1);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        rr_d     = rr_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        fert_d   = fert_q;
        pend_clr = 1'b0;
        case (state_q)
            FILL: begin
                if (level_q == '1)  state_d = SELECT;
                else if (tick_i)    level_d = level_q + 1'b1;
            end
            SELECT: begin
                if (found) begin
                    idx_d   = sel_idx;
                    mode_d  = sel_mode;
                    rr_d    = sel_idx;
                    tcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = WATER;
                    if (sel_mode == 2'b10 && pend_q && int'(level_q) >= 2) begin
                        fert_d   = 1'b1;
                        pend_clr = 1'b1;
                    end
                end
            end
            WATER: begin
                if (level_q == '0) begin
                    state_d = fert_q ? CLEAN : FILL;
                    fert_d  = 1'b0;
                    tcnt_d  = '0;
                end else if (live_mode != mode_q) begin
                    state_d = SELECT;
                    fert_d  = 1'b0;
                end else if (dcnt_q == DW'(QUANTUM)) begin
                    state_d = fert_q ? CLEAN : SELECT;
                    fert_d  = 1'b0;
                    tcnt_d  = '0;
                end else if (tick_i) begin
                    if (tcnt_q == lim_m1) begin
                        level_d = level_q - 1'b1;
                        tcnt_d  = '0;
                        dcnt_d  = dcnt_q + 1'b1;
                    end else begin
                        tcnt_d  = tcnt_q + 1'b1;
                    end
                end
            end
            CLEAN: begin
                if (tick_i) begin
                    if (tcnt_q == CW'(CLEAN_TICKS - 1)) begin
                        state_d = (level_q == '0) ? FILL : SELECT;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d  = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        // A new request in the clearing cycle wins, so pending survives.
        pend_d = (pend_q & ~pend_clr) | fertilise_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            level_q    <= '0;
            rr_q       <= PW'(ZONES - 1);
            idx_q      <= '0;
            mode_q     <= 2'b00;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            pend_q     <= 1'b0;
            fert_q     <= 1'b0;
            filling_q  <= 1'b1;
            watering_q <= 1'b0;
            cleaning_q <= 1'b0;
            alarm_q    <= 1'b0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            pend_q     <= pend_d;
            fert_q     <= fert_d;
            filling_q  <= (state_d == FILL);
            watering_q <= (state_d == WATER);
            cleaning_q <= (state_d == CLEAN);
            alarm_q    <= pend_d && (int'(level_d) <= 1);
            active_q   <= (state_d == WATER || state_d == CLEAN) ? (ZONES'(1) << idx_d) : '0;
        end
    end

    assign water_level_o = level_q;
    assign filling_o     = filling_q;
    assign watering_o    = watering_q;
    assign cleaning_o    = cleaning_q;
    assign fertilising_o = fert_q;
    assign alarm_o       = alarm_q;
    assign active_zone_o = active_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed scenarios plus randomized traffic, each cycle checked against a
// countdown-based reference model of the scheduler.
module tb_irrigation_zone_scheduler;
    localparam int Z = 4, LB = 3, DRIP = 4, SPRAY = 2, Q = 2, CLN = 3;
    localparam int FULL = (1 << LB) - 1;
    localparam int P_FILL = 0, P_SEL = 1, P_WAT = 2, P_CLN = 3;

    logic clk = 1'b0, rst = 1'b0, tick = 1'b0, freq = 1'b0;
    logic [2*Z-1:0] zm = '0;
    logic [LB-1:0] level;
    logic filling, watering, fertilising, cleaning, alarm;
    logic [Z-1:0] active, zerr;

    int total = 0, bad = 0;

    // reference model state
    int ph, lvl, rr, zone, zmode, left_ticks, left_drops, left_clean;
    bit pend, fert;

    irrigation_zone_scheduler #(.ZONES(Z), .LEVEL_BITS(LB), .DRIP_TICKS(DRIP),
        .SPRAY_TICKS(SPRAY), .QUANTUM(Q), .CLEAN_TICKS(CLN)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .zone_mode_i(zm),
        .fertilise_req_i(freq), .water_level_o(level), .filling_o(filling),
        .watering_o(watering), .active_zone_o(active), .fertilising_o(fertilising),
        .cleaning_o(cleaning), .alarm_o(alarm), .zone_error_o(zerr));

    always #5 clk = ~clk;

    function automatic int mode_of(input int j);
        return int'(zm[2*j +: 2]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_FILL; lvl = 0; rr = Z - 1; zone = 0; zmode = 0;
        left_ticks = 0; left_drops = 0; left_clean = 0; pend = 0; fert = 0;
    endtask

    task automatic model_step();
        bit cleared = 0;
        bit got = 0;
        case (ph)
            P_FILL: begin
                if (lvl == FULL) ph = P_SEL;
                else if (tick) lvl++;
            end
            P_SEL: begin
                for (int k = 1; k <= Z; k++) begin
                    int j = (rr + k) % Z;
                    int md = mode_of(j);
                    if (!got && (md == 1 || md == 2)) begin
                        got = 1; zone = j; zmode = md; rr = j; ph = P_WAT;
                        left_ticks = (md == 2) ? SPRAY : DRIP;
                        left_drops = Q;
                        if (md == 2 && pend && lvl >= 2) begin fert = 1; cleared = 1; end
                    end
                end
            end
            P_WAT: begin
                if (lvl == 0) begin
                    ph = fert ? P_CLN : P_FILL; left_clean = CLN; fert = 0;
                end else if (mode_of(zone) != zmode) begin
                    ph = P_SEL; fert = 0;
                end else if (left_drops == 0) begin
                    ph = fert ? P_CLN : P_SEL; left_clean = CLN; fert = 0;
                end else if (tick) begin
                    left_ticks--;
                    if (left_ticks == 0) begin
                        lvl--; left_drops--;
                        left_ticks = (zmode == 2) ? SPRAY : DRIP;
                    end
                end
            end
            default: begin
                if (tick) begin
                    left_clean--;
                    if (left_clean == 0) ph = (lvl == 0) ? P_FILL : P_SEL;
                end
            end
        endcase
        pend = (pend && !cleared) || freq;
    endtask

    task automatic check_all();
        int exp_act = (ph == P_WAT || ph == P_CLN) ? (1 << zone) : 0;
        int exp_err = 0;
        for (int j = 0; j < Z; j++) if (mode_of(j) == 3) exp_err |= (1 << j);
        chk("level", int'(level), lvl);
        chk("filling", int'(filling), int'(ph == P_FILL));
        chk("watering", int'(watering), int'(ph == P_WAT));
        chk("cleaning", int'(cleaning), int'(ph == P_CLN));
        chk("fertilising", int'(fertilising), int'(fert));
        chk("alarm", int'(alarm), int'(pend && lvl <= 1));
        chk("active_zone", int'(active), exp_act);
        chk("zone_error", int'(zerr), exp_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // which: 0 watering, 1 cleaning, 2 level==1, 3 zone 1 watering
    task automatic wait_for(input int which, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            case (which)
                0: ok = watering;
                1: ok = cleaning;
                2: ok = (level == 1);
                default: ok = watering && active == 4'b0010;
            endcase
        end
        chk(tag, int'(ok), 1);
    endtask

    initial begin
        model_reset();
        // all drip, tick every cycle
        zm = 8'b01_01_01_01; tick = 1'b1;
        do_reset();
        wait_for(0, 20, "wait_first_water");
        chk("first_zone", int'(active), 1);
        chk("first_level", int'(level), FULL);
        run(12);
        // spray zone 2 only, fertilise during fill
        zm = 8'b00_10_00_00;
        do_reset();
        run(2);
        freq = 1'b1; step(); freq = 1'b0;
        wait_for(1, 40, "wait_clean");
        run(6);
        // drain to level 1 on a drip zone, then request fertiliser
        zm = 8'b00_00_00_01;
        wait_for(2, 200, "wait_level1");
        freq = 1'b1; step(); freq = 1'b0;
        chk("alarm_set", int'(alarm), 1);
        zm = 8'b00_10_00_00;
        run(60);
        // invalidate zone 1 mid-turn
        zm = 8'b01_01_01_01;
        wait_for(3, 200, "wait_zone1");
        zm[3:2] = 2'b11;
        run(30);
        zm[3:2] = 2'b01;
        run(30);
        // everything off: idle in select
        zm = '0;
        run(20);
        chk("idle_watering", int'(watering), 0);
        chk("idle_active", int'(active), 0);
        // reset during a clean phase
        zm = 8'b10_00_00_00;
        freq = 1'b1; step(); freq = 1'b0;
        wait_for(1, 60, "wait_clean2");
        do_reset();
        chk("rst_level", int'(level), 0);
        chk("rst_filling", int'(filling), 1);
        // randomized traffic
        zm = 8'b10_01_10_01;
        for (int i = 0; i < 4000; i++) begin
            tick = 1'($urandom_range(0, 1));
            freq = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) begin
                int z = $urandom_range(0, Z - 1);
                zm[2*z +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
